// File: rtl/clk_div_ctrl_if.sv
// Ratio-update handshake bundle for clk_div_ctrl.
// The master offers a ratio on cfg_valid/cfg_div and the slave answers with cfg_ready.
interface clk_div_ctrl_if #(
  parameter int unsigned CNT_W = 4
);
  logic             cfg_valid;
  logic [CNT_W-1:0] cfg_div;
  logic             cfg_ready;

  modport master (output cfg_valid, output cfg_div, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_div, output cfg_ready);
endinterface

// File: rtl/clk_div_ctrl.sv
// Programmable clock-enable / divided-clock generator. Ratio updates are deferred to period boundaries.
// Optional macro CLK_DIV_CTRL_PERIOD_CNT_EN adds the saturating 16-bit period_cnt output.
module clk_div_ctrl #(
  parameter int unsigned CNT_W       = 4,
  parameter int unsigned DEFAULT_DIV = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  clk_div_ctrl_if.slave    cfg,
  output logic             en_pulse,
  output logic             div_clk,
  output logic [CNT_W-1:0] cnt,
  output logic             busy,
  output logic             err
`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
  ,
  output logic [15:0]      period_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W:0]   ONE_W   = (CNT_W+1)'(1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt_n;
  logic [CNT_W-1:0] div_reg, div_n;
  logic [CNT_W-1:0] pend_reg, pend_n;
  logic             pend_vld, pvld_n;
  logic             cfg_fire, cfg_take, wrap;
  logic [CNT_W:0]   half_n;

  assign cfg.cfg_ready = ~pend_vld;
  assign cfg_fire      = cfg.cfg_valid && !pend_vld;
  assign cfg_take      = cfg_fire && (cfg.cfg_div != '0);
  assign wrap          = (state != IDLE) && (cnt == div_reg - ONE);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    div_n   = div_reg;
    pend_n  = pend_reg;
    pvld_n  = pend_vld;
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        if (cfg_take) div_n = cfg.cfg_div;
        if (run) state_n = RUN;
      end
      RUN, DRAIN: begin
        if (wrap) begin
          cnt_n = '0;
          // Only one of these can hold: cfg_ready is low whenever a ratio is pending.
          if (pend_vld) begin
            div_n  = pend_reg;
            pvld_n = 1'b0;
          end else if (cfg_take) begin
            div_n = cfg.cfg_div;
          end
          state_n = run ? RUN : IDLE;
        end else begin
          cnt_n = cnt + ONE;
          if (cfg_take) begin
            pend_n = cfg.cfg_div;
            pvld_n = 1'b1;
          end
          state_n = run ? RUN : DRAIN;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Outputs are registered from next-state values so they line up with cnt/state.
  assign half_n = ({1'b0, div_n} + ONE_W) >> 1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      div_reg  <= DIV_RST;
      pend_reg <= '0;
      pend_vld <= 1'b0;
      err      <= 1'b0;
      en_pulse <= 1'b0;
      div_clk  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      div_reg  <= div_n;
      pend_reg <= pend_n;
      pend_vld <= pvld_n;
      err      <= cfg_fire && (cfg.cfg_div == '0);
      en_pulse <= (state_n != IDLE) && (cnt_n == div_n - ONE);
      div_clk  <= (state_n != IDLE) && ({1'b0, cnt_n} < half_n);
      busy     <= (state_n != IDLE);
    end
  end

`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      period_cnt <= '0;
    end else if (state == IDLE && run) begin
      period_cnt <= '0;
    end else if (en_pulse && period_cnt != '1) begin
      period_cnt <= period_cnt + 16'd1;
    end
  end
`endif

endmodule
